md5_core_iter: RTL

Iterative single-block MD5 engine used by the password-cracking top level. Each engine is fed one 8-character ASCII candidate and produces its 128-bit digest, plus a match flag against a target hash. Ten instances run in parallel, each walking its own slice of the "00000000".."99999999" space. The engine does one MD5 step per clock, 64 steps per message, with on-the-fly padding for the fixed 8-byte length.

---
 rtl/md5_core_iter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/md5_core_iter.sv
// md5_core_iter: iterative single-block MD5 engine for fixed 8-byte messages.
// A start accepts one 64-bit ASCII candidate. The engine then runs one MD5 step
// per clock for 64 clocks and finalises the digest on the next clock. The result
// is presented in hex-string byte order and is compared against a target digest.
// Padding for the 64-bit message length is hard-wired into the message word mux.
module md5_core_iter (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in,
   input  logic [63:0]  txt,
   input  logic [127:0] target,
   output logic         ready,
   output logic         valid,
   output logic [127:0] hash,
   output logic         match
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;

   localparam logic [31:0] INIT_A = 32'h67452301;
   localparam logic [31:0] INIT_B = 32'hefcdab89;
   localparam logic [31:0] INIT_C = 32'h98badcfe;
   localparam logic [31:0] INIT_D = 32'h10325476;

   // Per-step additive constants, floor(2^32 * |sin(i+1)|).
   function automatic logic [31:0] k_const(input logic [5:0] i);
      logic [31:0] k;
      case (i)
         6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;
         6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
         6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;
         6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
         6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;
         6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
         6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;
         6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
         6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;
         6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
         6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;
         6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
         6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;
         6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
         6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;
         6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
         6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;
         6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
         6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;
         6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
         6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;
         6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
         6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;
         6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
         6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;
         6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
         6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;
         6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
         6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;
         6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
         6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;
         6'd62: k = 32'h2ad7d2bb;  default: k = 32'heb86d391;
      endcase
      return k;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [5:0]   step_q, step_d;
   logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [63:0]  msg_q, msg_d;
   logic [127:0] hash_q, hash_d;
   logic         valid_q, valid_d;
   logic         match_q, match_d;

   logic [31:0]  m0_word, m1_word;
   logic [31:0]  fa, fb, fc, fd;
   logic [127:0] fin_hash;

   logic [31:0]  f_val, m_val, sum_val, rot_val, new_b;
   logic [3:0]   g_idx;
   logic [4:0]   s_amt;

   // Little-endian message words: the first character is the LSB of M0.
   // The final words are emitted least-significant byte first, in order a, b, c, d.
   for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign m0_word[8*gi +: 8]        = msg_q[63-8*gi -: 8];
      assign m1_word[8*gi +: 8]        = msg_q[31-8*gi -: 8];
      assign fin_hash[127-8*gi -: 8]   = fa[8*gi +: 8];
      assign fin_hash[95-8*gi -: 8]    = fb[8*gi +: 8];
      assign fin_hash[63-8*gi -: 8]    = fc[8*gi +: 8];
      assign fin_hash[31-8*gi -: 8]    = fd[8*gi +: 8];
   end

   assign fa = a_q + INIT_A;
   assign fb = b_q + INIT_B;
   assign fc = c_q + INIT_C;
   assign fd = d_q + INIT_D;

   // Round function, message schedule index and rotate amount for the current step.
   always_comb begin
      f_val = 32'h0;
      g_idx = 4'd0;
      case (step_q[5:4])
         2'd0: begin
            f_val = (b_q & c_q) | (~b_q & d_q);
            g_idx = step_q[3:0];
         end
         2'd1: begin
            f_val = (d_q & b_q) | (~d_q & c_q);
            g_idx = step_q[3:0] * 4'd5 + 4'd1;
         end
         2'd2: begin
            f_val = b_q ^ c_q ^ d_q;
            g_idx = step_q[3:0] * 4'd3 + 4'd5;
         end
         default: begin
            f_val = c_q ^ (b_q | ~d_q);
            g_idx = step_q[3:0] * 4'd7;
         end
      endcase

      case ({step_q[5:4], step_q[1:0]})
         4'h0: s_amt = 5'd7;   4'h1: s_amt = 5'd12;
         4'h2: s_amt = 5'd17;  4'h3: s_amt = 5'd22;
         4'h4: s_amt = 5'd5;   4'h5: s_amt = 5'd9;
         4'h6: s_amt = 5'd14;  4'h7: s_amt = 5'd20;
         4'h8: s_amt = 5'd4;   4'h9: s_amt = 5'd11;
         4'ha: s_amt = 5'd16;  4'hb: s_amt = 5'd23;
         4'hc: s_amt = 5'd6;   4'hd: s_amt = 5'd10;
         4'he: s_amt = 5'd15;  default: s_amt = 5'd21;
      endcase

      // Padding is fixed: 0x80 marker after 8 bytes, length 64 bits in M14.
      case (g_idx)
         4'd0:    m_val = m0_word;
         4'd1:    m_val = m1_word;
         4'd2:    m_val = 32'h00000080;
         4'd14:   m_val = 32'h00000040;
         default: m_val = 32'h0;
      endcase

      sum_val = a_q + f_val + k_const(step_q) + m_val;
      // s_amt is never zero, so the right shift stays below 32.
      rot_val = (sum_val << s_amt) | (sum_val >> (6'd32 - {1'b0, s_amt}));
      new_b   = b_q + rot_val;
   end

   // Next-state logic for the IDLE -> ROUND -> FINAL sequence.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      msg_d   = msg_q;
      hash_d  = hash_q;
      match_d = match_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in) begin
               msg_d   = txt;
               a_d     = INIT_A;
               b_d     = INIT_B;
               c_d     = INIT_C;
               d_d     = INIT_D;
               step_d  = 6'd0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            a_d    = d_q;
            d_d    = c_q;
            c_d    = b_q;
            b_d    = new_b;
            step_d = step_q + 6'd1;
            if (step_q == 6'd63) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            hash_d  = fin_hash;
            match_d = (fin_hash == target);
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any message in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         step_q  <= 6'd0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         c_q     <= 32'h0;
         d_q     <= 32'h0;
         msg_q   <= 64'h0;
         hash_q  <= 128'h0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         msg_q   <= msg_d;
         hash_q  <= hash_d;
         valid_q <= valid_d;
         match_q <= match_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign valid = valid_q;
   assign hash  = hash_q;
   assign match = match_q;

endmodule
